// File: rtl/divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface divider_if #(parameter int N = 4);
    logic         start;
    logic         ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, N iterations,
// registered results held until the next operation completes.
module divider #(
    parameter int N = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a;
    logic [N-1:0]  d;
    logic [N:0]    r;
    logic [CW-1:0] cnt;
    logic [N:0]    r_sh;
    logic [N:0]    t;

    // Trial subtraction for the current iteration; t[N] set means it went negative.
    always_comb begin
        r_sh = {r[N-1:0], a[N-1]};
        t    = r_sh - {1'b0, d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            a               <= '0;
            d               <= '0;
            r               <= '0;
            cnt             <= '0;
            bus.ready       <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) state <= LOAD;
                end
                LOAD: begin
                    a     <= bus.dividend;
                    d     <= bus.divisor;
                    r     <= '0;
                    cnt   <= CW'(N);
                    state <= CALC;
                end
                CALC: begin
                    a   <= {a[N-2:0], ~t[N]};
                    r   <= t[N] ? r_sh : t;
                    cnt <= cnt - 1'b1;
                    // Leave on the edge that runs the last iteration.
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    bus.quotient    <= a;
                    bus.remainder   <= r[N-1:0];
                    bus.div_by_zero <= (d == '0);
                    bus.ready       <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: arithmetic reference model with a per-cycle
// compare process, plus literal expectations on the directed cases.
module tb_divider;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   ready_at = -1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    // Held (visible) expected outputs and the result of the operation in flight.
    logic [N-1:0] hq = '0, hr = '0, pq = '0, pr = '0;
    logic         hz = 1'b0, pz = 1'b0;

    divider_if #(.N(N)) bus ();
    divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y);
        if (y == 0) begin
            pq = '1; pr = x; pz = 1'b1;
        end else begin
            pq = x / y; pr = x % y; pz = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            logic exp_rdy;
            exp_rdy = (cyc == ready_at);
            if (exp_rdy) begin
                hq = pq; hr = pr; hz = pz;
            end
            check("ready", 32'(bus.ready), 32'(exp_rdy));
            check("quotient", 32'(bus.quotient), 32'(hq));
            check("remainder", 32'(bus.remainder), 32'(hr));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(hz));
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 4 * N + 8 && cyc < ready_at; i++) @(negedge clk);
        if (cyc < ready_at) begin
            errors++;
            $display("FAIL wait_ready: timed out at cycle %0d expected ready at %0d", cyc, ready_at);
        end
    endtask

    task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = x; bus.divisor = y;
        @(posedge clk); #1;
        model(x, y);
        ready_at = cyc + N + 2;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y);
        launch(x, y);
        wait_ready();
    endtask

    task automatic lit(input string name, input logic [N-1:0] q, input logic [N-1:0] r, input logic z);
        check({name, "_q"}, 32'(bus.quotient), 32'(q));
        check({name, "_r"}, 32'(bus.remainder), 32'(r));
        check({name, "_z"}, 32'(bus.div_by_zero), 32'(z));
    endtask

    initial begin
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(bus.ready), 0);
        check("reset_q", 32'(bus.quotient), 0);
        check("reset_r", 32'(bus.remainder), 0);
        check("reset_z", 32'(bus.div_by_zero), 0);
        #2 rst_n = 1'b1; chk_en = 1'b1;

        // Directed cases with hand-computed results.
        do_op(4'd13, 4'd4);  lit("13_4", 4'd3, 4'd1, 1'b0);
        do_op(4'd15, 4'd1);  lit("15_1", 4'd15, 4'd0, 1'b0);
        do_op(4'd3, 4'd9);   lit("3_9", 4'd0, 4'd3, 1'b0);
        do_op(4'd0, 4'd5);   lit("0_5", 4'd0, 4'd0, 1'b0);
        do_op(4'd7, 4'd0);   lit("7_0", 4'd15, 4'd7, 1'b1);
        do_op(4'd8, 4'd2);   lit("8_2", 4'd4, 4'd0, 1'b0);

        // start and new operands during CALC must be ignored.
        launch(4'd14, 4'd3);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd5; bus.divisor = 4'd5;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_ready();
        lit("busy_14_3", 4'd4, 4'd2, 1'b0);
        repeat (3) @(negedge clk);

        // start held high: one operation every N+3 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd11; bus.divisor = 4'd2;
        @(posedge clk); #1;
        model(4'd11, 4'd2);
        ready_at = cyc + N + 2;
        for (int k = 0; k < 3; k++) begin
            wait_ready();
            if (k == 0) lit("b2b_11_2", 4'd5, 4'd1, 1'b0);
            if (k == 1) lit("b2b_10_3", 4'd3, 4'd1, 1'b0);
            if (k == 2) begin
                lit("b2b_9_4", 4'd2, 4'd1, 1'b0);
                bus.start = 1'b0;
            end else begin
                @(posedge clk); #1;
                bus.dividend = 4'(10 - k); bus.divisor = 4'(3 + k);
                model(4'(10 - k), 4'(3 + k));
                ready_at = cyc + N + 2;
            end
        end

        // Reset in the middle of CALC clears outputs immediately.
        launch(4'd11, 4'd3);
        ready_at = -1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready), 0);
        check("midrst_q", 32'(bus.quotient), 0);
        check("midrst_r", 32'(bus.remainder), 0);
        check("midrst_z", 32'(bus.div_by_zero), 0);
        hq = '0; hr = '0; hz = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        do_op(4'd9, 4'd2);   lit("9_2", 4'd4, 4'd1, 1'b0);

        // Every operand pair against the model.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_op(4'(x), 4'(y));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
